// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song ROM walker that drives a wave generator note by note
//
// Purpose: reads 32 song entries ({note code, beats}) from a registered ROM,
// plays each note for beats*BEAT_CYCLES clocks followed by GAP_CYCLES of silence.
// Optional build macro: NOTE_SEQ_LOOP_EN (restart from entry 0 instead of stopping).
//
// Ports:
//   clock      in   1   rising-edge clock
//   reset      in   1   synchronous, active-low reset
//   start      in   1   begin playback from entry 0 (IDLE only)
//   stop       in   1   abort playback
//   song_addr  out  5   song ROM address
//   song_data  in   8   ROM data, [7:4] note code, [3:0] beats, one cycle latency
//   play_note  out  1   note-active strobe
//   hz         out 32   wave period in clocks for the current note (0 for rests)
//   duration   out  4   beat count of the current entry
//   busy       out  1   high whenever not IDLE
//   song_done  out  1   one-cycle pulse on normal completion of a pass
module note_sequencer #(
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic [4:0]  song_addr,
  input  logic [7:0]  song_data,
  output logic        play_note,
  output logic [31:0] hz,
  output logic [3:0]  duration,
  output logic        busy,
  output logic        song_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] PLAY  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

`ifdef NOTE_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic [2:0]  state;
  logic [31:0] cycle_cnt;   // clocks within the current beat, reused for the gap
  logic [3:0]  beat_cnt;    // completed beats of the current note
  logic [31:0] note_hz;

  // Codes 1-12 map to C4..B4; everything else is a rest.
  always_comb begin
    note_hz = 32'd0;
    case (song_data[7:4])
      4'd1:    note_hz = 32'd191113;
      4'd2:    note_hz = 32'd180388;
      4'd3:    note_hz = 32'd170265;
      4'd4:    note_hz = 32'd160705;
      4'd5:    note_hz = 32'd151685;
      4'd6:    note_hz = 32'd143172;
      4'd7:    note_hz = 32'd135139;
      4'd8:    note_hz = 32'd127551;
      4'd9:    note_hz = 32'd120395;
      4'd10:   note_hz = 32'd113636;
      4'd11:   note_hz = 32'd107259;
      4'd12:   note_hz = 32'd101239;
      default: note_hz = 32'd0;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      song_addr <= 5'd0;
      play_note <= 1'b0;
      hz        <= 32'd0;
      duration  <= 4'd0;
      song_done <= 1'b0;
      cycle_cnt <= 32'd0;
      beat_cnt  <= 4'd0;
    end else if (stop && state != IDLE) begin
      // Abort: hz/duration deliberately keep the last note's values.
      state     <= IDLE;
      song_addr <= 5'd0;
      play_note <= 1'b0;
      song_done <= 1'b0;
      cycle_cnt <= 32'd0;
      beat_cnt  <= 4'd0;
    end else begin
      song_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            song_addr <= 5'd0;
            state     <= FETCH;
          end
        end
        // ROM registers the address during FETCH; data is valid in WAIT.
        FETCH: state <= WAIT;
        WAIT: begin
          if (song_data[3:0] == 4'd0) begin
            song_done <= 1'b1;
            if (LOOP_EN) begin
              song_addr <= 5'd0;
              state     <= FETCH;
            end else begin
              state <= DONE;
            end
          end else begin
            duration  <= song_data[3:0];
            hz        <= note_hz;
            play_note <= (note_hz != 32'd0);
            cycle_cnt <= 32'd0;
            beat_cnt  <= 4'd0;
            state     <= PLAY;
          end
        end
        PLAY: begin
          if (cycle_cnt == BEAT_LAST) begin
            cycle_cnt <= 32'd0;
            if (beat_cnt == duration - 4'd1) begin
              beat_cnt  <= 4'd0;
              play_note <= 1'b0;
              state     <= GAP;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
          end
        end
        GAP: begin
          if (cycle_cnt == GAP_LAST) begin
            cycle_cnt <= 32'd0;
            if (song_addr == 5'd31) begin
              song_done <= 1'b1;
              if (LOOP_EN) begin
                song_addr <= 5'd0;
                state     <= FETCH;
              end else begin
                state <= DONE;
              end
            end else begin
              song_addr <= song_addr + 5'd1;
              state     <= FETCH;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
          end
        end
        DONE: begin
          song_addr <= 5'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer
module tb_note_sequencer;

  localparam int BEAT = 4;
  localparam int GAPC = 2;
`ifdef NOTE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam int unsigned TONE [16] = '{0, 191113, 180388, 170265, 160705, 151685,
                                        143172, 135139, 127551, 120395, 113636,
                                        107259, 101239, 0, 0, 0};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [4:0]  song_addr;
  logic [7:0]  song_data = 8'd0;
  logic        play_note;
  logic [31:0] hz;
  logic [3:0]  duration;
  logic        busy;
  logic        song_done;

  note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .song_addr(song_addr), .song_data(song_data), .play_note(play_note),
    .hz(hz), .duration(duration), .busy(busy), .song_done(song_done)
  );

  always #5 clock = ~clock;

  logic [7:0] rom [32];
  always @(posedge clock) song_data <= rom[song_addr];

  typedef struct packed {
    logic        play;
    logic [31:0] hz;
    logic [3:0]  dur;
    logic        busy;
    logic        done;
    logic [4:0]  addr;
  } rec_t;

  int checks = 0;
  int failures = 0;

  // Expected output timeline: one record per clock cycle of playback.
  rec_t        q[$];
  rec_t        cur;
  bit          active = 1'b0;
  bit          model_valid = 1'b0;
  logic [31:0] bhz;
  logic [3:0]  bdur;

  task automatic push_rec(input logic p, input logic d, input int a);
    rec_t r;
    r.play = p; r.hz = bhz; r.dur = bdur; r.busy = 1'b1; r.done = d; r.addr = 5'(a);
    q.push_back(r);
  endtask

  // One pass over the song: fetch 2 clocks, play beats*BEAT, gap GAPC per entry.
  task automatic append_pass(input bit first_done);
    int beats;
    int last = 0;
    for (int i = 0; i < 32; i++) begin
      push_rec(1'b0, first_done && i == 0, i);
      push_rec(1'b0, 1'b0, i);
      last = i;
      beats = int'(rom[i][3:0]);
      if (beats == 0) break;
      bhz  = TONE[rom[i][7:4]];
      bdur = rom[i][3:0];
      repeat (beats * BEAT) push_rec(bhz != 0, 1'b0, i);
      repeat (GAPC) push_rec(1'b0, 1'b0, i);
    end
    if (!LOOP) push_rec(1'b0, 1'b1, last);
  endtask

  task automatic go_idle();
    cur.play = 1'b0; cur.busy = 1'b0; cur.done = 1'b0; cur.addr = 5'd0;
  endtask

  always @(posedge clock) begin
    if (!reset) begin
      q.delete();
      active = 1'b0;
      cur = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (active && stop) begin
        q.delete();
        active = 1'b0;
        go_idle();
      end else begin
        if (!active && start && !stop) begin
          active = 1'b1;
          bhz = cur.hz;
          bdur = cur.dur;
          append_pass(1'b0);
        end
        if (active) begin
          if (q.size() == 0 && LOOP) append_pass(1'b1);
          if (q.size() == 0) begin
            active = 1'b0;
            go_idle();
          end else begin
            cur = q.pop_front();
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus activity counters.
  int play_cnt, busy_cnt, done_cnt, rise_cnt, idle_cnt;
  logic prev_play = 1'b0;

  always @(negedge clock) begin
    rec_t d;
    if (model_valid) begin
      d.play = play_note; d.hz = hz; d.dur = duration;
      d.busy = busy; d.done = song_done; d.addr = song_addr;
      checks++;
      if (d !== cur) begin
        failures++;
        $display("FAIL model t=%0t actual play=%b hz=%0d dur=%0d busy=%b done=%b addr=%0d required play=%b hz=%0d dur=%0d busy=%b done=%b addr=%0d",
                 $time, d.play, d.hz, d.dur, d.busy, d.done, d.addr,
                 cur.play, cur.hz, cur.dur, cur.busy, cur.done, cur.addr);
      end
      play_cnt += int'(play_note);
      busy_cnt += int'(busy);
      done_cnt += int'(song_done);
      idle_cnt += int'(!busy);
      if (play_note && !prev_play) rise_cnt++;
      prev_play = play_note;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic clear_song();
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
  endtask

  task automatic start_song();
    play_cnt = 0; busy_cnt = 0; done_cnt = 0; rise_cnt = 0; idle_cnt = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (busy && n < limit) begin
      tick(1);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_song();
    tick(3);
    check("reset_play", 32'(play_note), 0);
    check("reset_hz", hz, 0);
    check("reset_dur", 32'(duration), 0);
    check("reset_addr", 32'(song_addr), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(song_done), 0);
    reset = 1'b1;
    tick(2);

`ifndef NOTE_SEQ_LOOP_EN
    // Single note then end marker.
    rom[0] = 8'h12; rom[1] = 8'h00;
    start_song();
    check("lat_fetch_busy", 32'(busy), 1);
    check("lat_fetch_play", 32'(play_note), 0);
    tick(1);
    check("lat_wait_play", 32'(play_note), 0);
    tick(1);
    check("lat_play_rise", 32'(play_note), 1);
    check("note_hz", hz, 191113);
    check("note_dur", 32'(duration), 2);
    wait_idle(60, "note_busy_falls");
    check("note_play_cycles", 32'(play_cnt), 8);
    check("note_busy_cycles", 32'(busy_cnt), 15);
    check("note_done_pulses", 32'(done_cnt), 1);
    tick(2);

    // Rest entry.
    clear_song();
    rom[0] = 8'h01;
    start_song();
    wait_idle(60, "rest_busy_falls");
    check("rest_play_cycles", 32'(play_cnt), 0);
    check("rest_busy_cycles", 32'(busy_cnt), 11);
    check("rest_hz", hz, 0);
    check("rest_dur", 32'(duration), 1);
    tick(2);
`endif

    // Stop during the third PLAY cycle.
    clear_song();
    rom[0] = 8'hA3;
    start_song();
    tick(4);
    check("stop_pre_play", 32'(play_note), 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_play", 32'(play_note), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_addr", 32'(song_addr), 0);
    tick(3);
    check("stop_no_done", 32'(done_cnt), 0);
    check("stop_hz_kept", hz, 113636);

`ifndef NOTE_SEQ_LOOP_EN
    // Full 32-entry song.
    for (int i = 0; i < 32; i++) rom[i] = 8'hC1;
    start_song();
    wait_idle(400, "full_busy_falls");
    check("full_notes", 32'(rise_cnt), 32);
    check("full_done", 32'(done_cnt), 1);
    check("full_busy_cycles", 32'(busy_cnt), 257);
    check("full_addr", 32'(song_addr), 0);
    check("full_hz", hz, 101239);
    tick(2);

    // Reset mid-PLAY with start held high.
    clear_song();
    rom[0] = 8'h34;
    start_song();
    tick(6);
    check("rst_pre_play", 32'(play_note), 1);
    start = 1'b1;
    reset = 1'b0;
    tick(1);
    check("rst_play", 32'(play_note), 0);
    check("rst_hz", hz, 0);
    check("rst_dur", 32'(duration), 0);
    check("rst_addr", 32'(song_addr), 0);
    check("rst_busy", 32'(busy), 0);
    tick(1);
    check("rst_held_busy", 32'(busy), 0);
    reset = 1'b1;
    tick(1);
    check("rst_resume_busy", 32'(busy), 1);
    start = 1'b0;
    wait_idle(80, "rst_resume_ends");
    check("rst_resume_hz", hz, 170265);
    tick(2);
`else
    // Looping playback.
    clear_song();
    rom[0] = 8'h51;
    start_song();
    tick(39);
    check("loop_notes", 32'(rise_cnt), 4);
    check("loop_done", 32'(done_cnt), 3);
    check("loop_never_idle", 32'(idle_cnt), 0);
    check("loop_hz", hz, 151685);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("loop_stop_busy", 32'(busy), 0);
    tick(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
